led_flow_ctrl: RTL and testbench

LED_FLOW_CTRL -- requirements
Module: led_flow_ctrl

---
 rtl/led_flow_ctrl_if.sv | 27 ++
 rtl/led_flow_ctrl.sv | 117 +++++++++++
 tb/tb_led_flow_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/led_flow_ctrl_if.sv
// Control/status bundle for the LED flow controller: run/mode/period in, pattern/step out.
interface led_flow_ctrl_if #(
  parameter int N_LED = 8,
  parameter int CNT_W = 24
);
  logic             en;
  logic [1:0]       mode;
  logic [CNT_W-1:0] div;
  logic [N_LED-1:0] led;
  logic             step;

  modport master (
    output en,
    output mode,
    output div,
    input  led,
    input  step
  );

  modport slave (
    input  en,
    input  mode,
    input  div,
    output led,
    output step
  );
endinterface

// File: rtl/led_flow_ctrl.sv
// Prescaled LED pattern generator: rotate-left/right, bounce and blink-all patterns.
// The pattern advances once every div+1 enabled cycles; step flags each update.
module led_flow_ctrl #(
  parameter int N_LED = 8,
  parameter int CNT_W = 24
) (
  input  logic            sys_clk50m,
  input  logic            rst_n,
  led_flow_ctrl_if.slave  ctrl
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  localparam logic [N_LED-1:0] SEED_LO  = N_LED'(1);
  localparam logic [N_LED-1:0] SEED_HI  = {1'b1, {(N_LED-1){1'b0}}};
  localparam logic [N_LED-1:0] ALL_ONES = {N_LED{1'b1}};
  localparam logic [N_LED-1:0] ALL_ZERO = {N_LED{1'b0}};

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [N_LED-1:0] led_q;
  logic [N_LED-1:0] led_next;
  logic             dir;
  logic             dir_next;
  logic             step_q;
  logic             tick;
  logic             one_hot;
  logic             all_ones;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(ctrl.mode);
  assign tick     = ctrl.en && (cnt == ctrl.div);
  assign one_hot  = (led_q != ALL_ZERO) && ((led_q & (led_q - N_LED'(1))) == ALL_ZERO);
  assign all_ones = (led_q == ALL_ONES);

  // A count above div (period shortened mid-count) restarts without ticking.
  always_comb begin
    cnt_next = cnt;
    if (ctrl.en) begin
      if (cnt >= ctrl.div) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    led_next = led_q;
    dir_next = dir;
    if (tick) begin
      case (mode_sel)
        MODE_ROL: begin
          if (!one_hot) begin
            led_next = SEED_LO;
            dir_next = 1'b0;
          end else begin
            led_next = {led_q[N_LED-2:0], led_q[N_LED-1]};
          end
        end
        MODE_ROR: begin
          if (!one_hot) begin
            led_next = SEED_HI;
          end else begin
            led_next = {led_q[0], led_q[N_LED-1:1]};
          end
        end
        MODE_BOUNCE: begin
          // End bits override the stored direction so the ends are never repeated.
          if (!one_hot) begin
            led_next = SEED_LO;
            dir_next = 1'b0;
          end else if (led_q[N_LED-1]) begin
            led_next = {1'b0, led_q[N_LED-1:1]};
            dir_next = 1'b1;
          end else if (led_q[0]) begin
            led_next = {led_q[N_LED-2:0], 1'b0};
            dir_next = 1'b0;
          end else if (dir) begin
            led_next = {1'b0, led_q[N_LED-1:1]};
          end else begin
            led_next = {led_q[N_LED-2:0], 1'b0};
          end
        end
        MODE_BLINK: begin
          led_next = all_ones ? ALL_ZERO : ALL_ONES;
        end
        default: begin
          led_next = led_q;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      led_q  <= '0;
      dir    <= 1'b0;
      step_q <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      led_q  <= led_next;
      dir    <= dir_next;
      step_q <= tick;
    end
  end

  assign ctrl.led  = led_q;
  assign ctrl.step = step_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl (N_LED=4): stimulus queues expected step events,
// a negedge monitor pops and compares them whenever step is seen or due.
module tb_led_flow_ctrl;

  localparam int N_LED = 4;
  localparam int CNT_W = 8;

  typedef struct {
    int              edge_no;
    logic [N_LED-1:0] led;
  } exp_t;

  logic sys_clk50m = 1'b0;
  logic rst_n      = 1'b0;
  int   cyc        = 0;
  int   n_vec      = 0;
  int   n_miss     = 0;
  exp_t sb_q[$];

  led_flow_ctrl_if #(.N_LED(N_LED), .CNT_W(CNT_W)) bus_if ();

  led_flow_ctrl #(.N_LED(N_LED), .CNT_W(CNT_W)) dut (
    .sys_clk50m (sys_clk50m),
    .rst_n      (rst_n),
    .ctrl       (bus_if.slave)
  );

  always #10 sys_clk50m = ~sys_clk50m;

  always @(posedge sys_clk50m) cyc++;

  // Monitor: every step must match the queue head's edge and pattern; a due entry without step is a miss.
  always @(negedge sys_clk50m) begin
    exp_t e;
    if (bus_if.step === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_miss++;
        $display("[TB] FAIL step_spurious: step=1 led=%b at edge %0d, required step=0", bus_if.led, cyc);
      end else begin
        e = sb_q.pop_front();
        if (e.edge_no != cyc || bus_if.led !== e.led) begin
          n_miss++;
          $display("[TB] FAIL step_led: got led=%b at edge %0d, required led=%b at edge %0d",
                   bus_if.led, cyc, e.led, e.edge_no);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].edge_no <= cyc) begin
      e = sb_q.pop_front();
      n_vec++;
      n_miss++;
      $display("[TB] FAIL step_missing: step=%b led=%b at edge %0d, required step=1 led=%b",
               bus_if.step, bus_if.led, cyc, e.led);
    end
  end

  task automatic apply_stimulus(input logic en, input logic [1:0] mode, input logic [CNT_W-1:0] div);
    bus_if.en   = en;
    bus_if.mode = mode;
    bus_if.div  = div;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge sys_clk50m);
  endtask

  task automatic expect_step(input int offset, input logic [N_LED-1:0] led);
    exp_t e;
    e.edge_no = cyc + offset;
    e.led     = led;
    sb_q.push_back(e);
  endtask

  task automatic check_output(input string name, input logic [N_LED-1:0] exp_led);
    n_vec++;
    if (bus_if.led !== exp_led) begin
      n_miss++;
      $display("[TB] FAIL %s_led: got %b, required %b", name, bus_if.led, exp_led);
    end
    n_vec++;
    if (bus_if.step !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL %s_step: got %b, required 0", name, bus_if.step);
    end
  endtask

  // Called at a negedge: reset spans one rising edge, released at the following negedge.
  task automatic reset_dut();
    #5 rst_n = 1'b0;
    #1 check_output("reset", 4'b0000);
    @(negedge sys_clk50m);
    rst_n = 1'b1;
  endtask

  initial begin
    apply_stimulus(1'b1, 2'b00, 8'd3);
    #5 check_output("por", 4'b0000);
    @(negedge sys_clk50m);
    rst_n = 1'b1;

    $display("[TB] rotate-left div=3");
    expect_step(4, 4'b0001);
    expect_step(8, 4'b0010);
    expect_step(12, 4'b0100);
    expect_step(16, 4'b1000);
    expect_step(20, 4'b0001);
    wait_edges(2);
    check_output("pre_tick", 4'b0000);
    wait_edges(18);

    $display("[TB] bounce div=0");
    apply_stimulus(1'b1, 2'b10, 8'd0);
    reset_dut();
    expect_step(1, 4'b0001);
    expect_step(2, 4'b0010);
    expect_step(3, 4'b0100);
    expect_step(4, 4'b1000);
    expect_step(5, 4'b0100);
    expect_step(6, 4'b0010);
    expect_step(7, 4'b0001);
    expect_step(8, 4'b0010);
    wait_edges(8);

    $display("[TB] blink then rotate-right mid-period");
    apply_stimulus(1'b1, 2'b11, 8'd3);
    reset_dut();
    expect_step(4, 4'b1111);
    expect_step(8, 4'b0000);
    expect_step(12, 4'b1111);
    wait_edges(13);
    apply_stimulus(1'b1, 2'b01, 8'd3);
    expect_step(3, 4'b1000);
    expect_step(7, 4'b0100);
    wait_edges(7);

    $display("[TB] div lowered mid-count");
    apply_stimulus(1'b1, 2'b00, 8'd9);
    reset_dut();
    wait_edges(7);
    apply_stimulus(1'b1, 2'b00, 8'd5);
    wait_edges(1);
    check_output("div_lowered", 4'b0000);
    expect_step(6, 4'b0001);
    expect_step(12, 4'b0010);
    wait_edges(12);

    $display("[TB] enable freeze");
    wait_edges(3);
    apply_stimulus(1'b0, 2'b00, 8'd5);
    for (int i = 0; i < 10; i++) begin
      wait_edges(1);
      check_output("frozen", 4'b0010);
    end
    apply_stimulus(1'b1, 2'b00, 8'd5);
    expect_step(3, 4'b0100);
    wait_edges(3);

    $display("[TB] async reset between edges during step");
    #3 rst_n = 1'b0;
    #1 check_output("async_reset", 4'b0000);
    #3 rst_n = 1'b1;
    @(negedge sys_clk50m);
    expect_step(5, 4'b0001);
    expect_step(11, 4'b0010);
    wait_edges(11);

    wait_edges(2);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL queue_drain: %0d expected steps never seen, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
